ppg_peak_detector: RTL and testbench

PPG_PEAK_DETECTOR -- requirements
Module: ppg_peak_detector

---
 rtl/ppg_pkg.sv | 22 ++
 rtl/ppg_interval_counter.sv | 55 +++++
 rtl/ppg_peak_detector.sv | 192 +++++++++++++++++++
 tb/tb_ppg_peak_detector.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/ppg_pkg.sv
// ppg_pkg: shared constants and the FSM state type for the PPG peak detector.
//   PPG_DATA_W        width of the signed filtered sample
//   PPG_CNT_W         width of the beat interval counter
//   PPG_HYST          default peak/valley confirmation hysteresis (LSBs)
//   PPG_MIN_INTERVAL  default refractory interval (samples)
//   PPG_MAX_INTERVAL  default no-pulse timeout (samples)
//   ppg_state_e       detector FSM states
package ppg_pkg;

  localparam int PPG_DATA_W       = 20;
  localparam int PPG_CNT_W        = 10;
  localparam int PPG_HYST         = 256;
  localparam int PPG_MIN_INTERVAL = 20;
  localparam int PPG_MAX_INTERVAL = 1023;

  typedef enum logic [1:0] {
    ST_ACQUIRE = 2'd0,
    ST_RISING  = 2'd1,
    ST_FALLING = 2'd2
  } ppg_state_e;

endpackage

// File: rtl/ppg_interval_counter.sv
// ppg_interval_counter: saturating sample counter measuring the beat interval.
// Ports:
//   clk_sampling  sample clock
//   rst           asynchronous active-low reset, clears count to 0
//   en_i          count this edge (one consumed sample)
//   clr_i         restart the interval; only acts together with en_i
//   count_o       current count
//   reach_max_o   this consumed edge takes the count up to MAX_VAL
module ppg_interval_counter
  import ppg_pkg::*;
#(
  parameter int CNT_W   = PPG_CNT_W,
  parameter int MAX_VAL = PPG_MAX_INTERVAL
) (
  input  logic             clk_sampling,
  input  logic             rst,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o,
  output logic             reach_max_o
);

  localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_VAL);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(MAX_VAL - 1);

  logic [CNT_W-1:0] count_q, count_d;

  // A restart loads 1, not 0: the sample that restarts the interval is
  // already the first sample of the new one.
  always_comb begin
    count_d = count_q;
    if (en_i) begin
      if (clr_i) begin
        count_d = CNT_W'(1);
      end else if (count_q < MAX_C) begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sampling or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

  // Fires only on the transition into saturation, so a timeout is a single
  // event rather than repeating on every later sample.
  assign reach_max_o = en_i && !clr_i && (count_q == LAST_C);

endmodule

// File: rtl/ppg_peak_detector.sv
// ppg_peak_detector: hysteresis peak/valley tracker producing beat interval
// and pulse amplitude from a filtered PPG stream.
// Ports:
//   clk_sampling   sample clock
//   rst            asynchronous active-low reset
//   sample_en      sample_in is consumed on this edge
//   sample_in      signed filtered sample
//   peak_val       last accepted peak
//   valley_val     last confirmed valley
//   ac_amp         peak minus valley at the last beat (unsigned)
//   beat_interval  samples between the last two accepted peaks
//   beat_valid     one-cycle pulse on a new beat
//   no_pulse       high while no peak has been accepted within MAX_INTERVAL
//
// state   | meaning
// ACQUIRE | no reference yet; next sample seeds run_max/run_min
// RISING  | tracking a maximum, waiting for a drop of more than HYST
// FALLING | tracking a minimum, waiting for a rise of more than HYST
module ppg_peak_detector
  import ppg_pkg::*;
#(
  parameter int DATA_W       = PPG_DATA_W,
  parameter int HYST         = PPG_HYST,
  parameter int MIN_INTERVAL = PPG_MIN_INTERVAL,
  parameter int MAX_INTERVAL = PPG_MAX_INTERVAL,
  parameter int CNT_W        = PPG_CNT_W
) (
  input  logic                     clk_sampling,
  input  logic                     rst,
  input  logic                     sample_en,
  input  logic signed [DATA_W-1:0] sample_in,
  output logic signed [DATA_W-1:0] peak_val,
  output logic signed [DATA_W-1:0] valley_val,
  output logic        [DATA_W:0]   ac_amp,
  output logic        [CNT_W-1:0]  beat_interval,
  output logic                     beat_valid,
  output logic                     no_pulse
);

  // Two guard bits keep threshold arithmetic exact at full-scale inputs.
  localparam int W2 = DATA_W + 2;
  localparam logic signed [W2-1:0] HYST_S = W2'(HYST);
  localparam logic [CNT_W-1:0]     MIN_C  = CNT_W'(MIN_INTERVAL);

  ppg_state_e state_q, state_d;
  logic signed [DATA_W-1:0] run_max_q, run_max_d;
  logic signed [DATA_W-1:0] run_min_q, run_min_d;
  logic signed [DATA_W-1:0] peak_val_q, peak_val_d;
  logic signed [DATA_W-1:0] valley_val_q, valley_val_d;
  logic [DATA_W:0]          ac_amp_q, ac_amp_d;
  logic [CNT_W-1:0]         beat_interval_q, beat_interval_d;
  logic                     beat_valid_q, beat_valid_d;
  logic                     no_pulse_q, no_pulse_d;
  logic                     peak_seen_q, peak_seen_d;
  logic                     valley_seen_q, valley_seen_d;

  logic signed [W2-1:0] samp_x, max_x, min_x, valley_x, amp_diff;
  logic [DATA_W:0]      amp_clip;
  logic [CNT_W-1:0]     cnt;
  logic                 cnt_reach_max;
  logic                 peak_hit, valley_hit, peak_accept, timeout;

  assign samp_x   = {{2{sample_in[DATA_W-1]}}, sample_in};
  assign max_x    = {{2{run_max_q[DATA_W-1]}}, run_max_q};
  assign min_x    = {{2{run_min_q[DATA_W-1]}}, run_min_q};
  assign valley_x = {{2{valley_val_q[DATA_W-1]}}, valley_val_q};

  // A valley above the new peak cannot happen with a sane waveform; clamp
  // to zero rather than report a huge unsigned amplitude.
  assign amp_diff = max_x - valley_x;
  assign amp_clip = amp_diff[W2-1] ? '0 : amp_diff[DATA_W:0];

  assign peak_hit    = (state_q == ST_RISING)  && (samp_x < (max_x - HYST_S));
  assign valley_hit  = (state_q == ST_FALLING) && (samp_x > (min_x + HYST_S));
  assign peak_accept = sample_en && peak_hit && (!peak_seen_q || (cnt >= MIN_C));
  assign timeout     = cnt_reach_max && !peak_accept;

  // A rejected peak does not restart the interval; counting continues so
  // the next accepted peak measures from the last accepted one.
  ppg_interval_counter #(
    .CNT_W   (CNT_W),
    .MAX_VAL (MAX_INTERVAL)
  ) u_interval_counter (
    .clk_sampling (clk_sampling),
    .rst          (rst),
    .en_i         (sample_en),
    .clr_i        (peak_accept),
    .count_o      (cnt),
    .reach_max_o  (cnt_reach_max)
  );

  always_comb begin
    state_d         = state_q;
    run_max_d       = run_max_q;
    run_min_d       = run_min_q;
    peak_val_d      = peak_val_q;
    valley_val_d    = valley_val_q;
    ac_amp_d        = ac_amp_q;
    beat_interval_d = beat_interval_q;
    beat_valid_d    = 1'b0;
    no_pulse_d      = no_pulse_q;
    peak_seen_d     = peak_seen_q;
    valley_seen_d   = valley_seen_q;

    if (sample_en) begin
      case (state_q)
        ST_ACQUIRE: begin
          run_max_d = sample_in;
          run_min_d = sample_in;
          state_d   = ST_RISING;
        end
        ST_RISING: begin
          if (peak_hit) begin
            state_d   = ST_FALLING;
            run_min_d = sample_in;
            if (peak_accept) begin
              peak_val_d  = run_max_q;
              peak_seen_d = 1'b1;
              no_pulse_d  = 1'b0;
              if (peak_seen_q && valley_seen_q) begin
                beat_interval_d = cnt;
                ac_amp_d        = amp_clip;
                beat_valid_d    = 1'b1;
              end
            end
          end else if (sample_in > run_max_q) begin
            run_max_d = sample_in;
          end
        end
        ST_FALLING: begin
          if (valley_hit) begin
            valley_val_d  = run_min_q;
            valley_seen_d = 1'b1;
            state_d       = ST_RISING;
            run_max_d     = sample_in;
          end else if (sample_in < run_min_q) begin
            run_min_d = sample_in;
          end
        end
        default: begin
          state_d = ST_ACQUIRE;
        end
      endcase

      // Timeout drops the beat history and restarts acquisition; reported
      // values are left as they were.
      if (timeout) begin
        no_pulse_d    = 1'b1;
        peak_seen_d   = 1'b0;
        valley_seen_d = 1'b0;
        valley_val_d  = valley_val_q;
        state_d       = ST_ACQUIRE;
      end
    end
  end

  always_ff @(posedge clk_sampling or negedge rst) begin
    if (!rst) begin
      state_q         <= ST_ACQUIRE;
      run_max_q       <= '0;
      run_min_q       <= '0;
      peak_val_q      <= '0;
      valley_val_q    <= '0;
      ac_amp_q        <= '0;
      beat_interval_q <= '0;
      beat_valid_q    <= 1'b0;
      no_pulse_q      <= 1'b0;
      peak_seen_q     <= 1'b0;
      valley_seen_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      run_max_q       <= run_max_d;
      run_min_q       <= run_min_d;
      peak_val_q      <= peak_val_d;
      valley_val_q    <= valley_val_d;
      ac_amp_q        <= ac_amp_d;
      beat_interval_q <= beat_interval_d;
      beat_valid_q    <= beat_valid_d;
      no_pulse_q      <= no_pulse_d;
      peak_seen_q     <= peak_seen_d;
      valley_seen_q   <= valley_seen_d;
    end
  end

  assign peak_val      = peak_val_q;
  assign valley_val    = valley_val_q;
  assign ac_amp        = ac_amp_q;
  assign beat_interval = beat_interval_q;
  assign beat_valid    = beat_valid_q;
  assign no_pulse      = no_pulse_q;

endmodule

// File: tb/tb_ppg_peak_detector.sv
// tb_ppg_peak_detector: directed bench for ppg_peak_detector with
// hand-computed expected values.
module tb_ppg_peak_detector;

  logic               clk_sampling = 1'b0;
  logic               rst;
  logic               sample_en;
  logic signed [19:0] sample_in;
  logic signed [19:0] peak_val;
  logic signed [19:0] valley_val;
  logic        [20:0] ac_amp;
  logic        [9:0]  beat_interval;
  logic               beat_valid;
  logic               no_pulse;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk_sampling = ~clk_sampling;

  ppg_peak_detector #(
    .DATA_W       (20),
    .HYST         (256),
    .MIN_INTERVAL (20),
    .MAX_INTERVAL (1023),
    .CNT_W        (10)
  ) dut (
    .clk_sampling  (clk_sampling),
    .rst           (rst),
    .sample_en     (sample_en),
    .sample_in     (sample_in),
    .peak_val      (peak_val),
    .valley_val    (valley_val),
    .ac_amp        (ac_amp),
    .beat_interval (beat_interval),
    .beat_valid    (beat_valid),
    .no_pulse      (no_pulse)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic en, input int val);
    sample_en = en;
    sample_in = 20'(val);
    @(posedge clk_sampling);
    #1;
  endtask

  task automatic do_reset();
    sample_en = 1'b0;
    sample_in = '0;
    rst = 1'b0;
    #2;
    chk("rst_peak_val", peak_val, 0);
    chk("rst_valley_val", valley_val, 0);
    chk("rst_ac_amp", ac_amp, 0);
    chk("rst_beat_interval", beat_interval, 0);
    chk("rst_beat_valid", beat_valid, 0);
    chk("rst_no_pulse", no_pulse, 0);
    @(negedge clk_sampling);
    rst = 1'b1;
  endtask

  // Triangle +-2000, period 50, peaks at phase 25, valleys at phase 0.
  function automatic int tri_val(input int n);
    int p;
    p = n % 50;
    return (p <= 25) ? (-2000 + 160 * p) : (2000 - 160 * (p - 25));
  endfunction

  // Peaks confirm two samples after the crest (drop of 320 > 256), so with
  // a fresh start the first beat lands on sample 77, then every 50.
  task automatic run_tri(input int start, input int stop, input bit gap,
                         input int first_beat);
    for (int n = start; n < stop; n++) begin
      bit exp_bv;
      if (gap) begin
        step(1'b0, -300000);
        chk("gap_beat_valid", beat_valid, 0);
      end
      step(1'b1, tri_val(n));
      exp_bv = (n >= first_beat) && (((n - first_beat) % 50) == 0);
      chk("tri_beat_valid", beat_valid, exp_bv);
      if (exp_bv) begin
        chk("tri_beat_interval", beat_interval, 50);
        chk("tri_ac_amp", ac_amp, 4000);
        chk("tri_peak_val", peak_val, 2000);
        chk("tri_valley_val", valley_val, -2000);
      end
    end
    chk("tri_no_pulse", no_pulse, 0);
  endtask

  initial begin
    rst       = 1'b1;
    sample_en = 1'b0;
    sample_in = '0;
    #1;

    // Continuous triangle
    do_reset();
    run_tri(0, 200, 1'b0, 77);

    // Same wave with sample_en at 50% duty: only consumed samples count
    do_reset();
    run_tri(0, 200, 1'b1, 77);

    // Reset after a valley, before the next peak; wave continues afterwards
    do_reset();
    run_tri(0, 111, 1'b0, 77);
    do_reset();
    run_tri(111, 260, 1'b0, 177);

    // Peaks of 3000 at samples 5, 15, 65: the 10-sample one is rejected
    do_reset();
    for (int n = 0; n < 70; n++) begin
      step(1'b1, (n == 5 || n == 15 || n == 65) ? 3000 : 0);
      chk("refr_beat_valid", beat_valid, (n == 66));
      if (n == 6) chk("refr_first_peak", peak_val, 3000);
      if (n == 16) chk("refr_rejected_interval", beat_interval, 0);
      if (n == 66) begin
        chk("refr_beat_interval", beat_interval, 60);
        chk("refr_ac_amp", ac_amp, 3000);
        chk("refr_valley_val", valley_val, 0);
      end
    end

    // Full-scale square wave, period 100, starting low
    do_reset();
    for (int n = 0; n < 202; n++) begin
      step(1'b1, (((n / 50) % 2) == 1) ? 524287 : -524288);
      chk("sq_beat_valid", beat_valid, (n == 200));
      if (n == 100) chk("sq_first_peak", peak_val, 524287);
      if (n == 200) begin
        chk("sq_beat_interval", beat_interval, 100);
        chk("sq_ac_amp", ac_amp, 1048575);
        chk("sq_peak_val", peak_val, 524287);
        chk("sq_valley_val", valley_val, -524288);
      end
    end

    // Flat input: timeout after 1023 consumed samples, never a beat
    do_reset();
    for (int n = 0; n < 1100; n++) begin
      step(1'b1, 0);
      chk("flat_no_pulse", no_pulse, (n >= 1022));
      chk("flat_beat_valid", beat_valid, 0);
    end
    chk("flat_peak_val", peak_val, 0);
    // First peak after a timeout clears no_pulse but reports no beat
    step(1'b1, 3000);
    step(1'b1, 0);
    chk("post_to_no_pulse", no_pulse, 0);
    chk("post_to_peak_val", peak_val, 3000);
    chk("post_to_beat_valid", beat_valid, 0);

    // Peak confirmed on the very edge the counter reaches 1023
    do_reset();
    for (int n = 0; n < 1021; n++) step(1'b1, 0);
    chk("prio_pre_no_pulse", no_pulse, 0);
    step(1'b1, 3000);
    step(1'b1, 0);
    chk("prio_no_pulse", no_pulse, 0);
    chk("prio_peak_val", peak_val, 3000);
    for (int n = 0; n < 5; n++) step(1'b1, 0);
    chk("prio_hold_no_pulse", no_pulse, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
